// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one memory-mapped UART transmitter between two
// byte-stream requesters with round-robin arbitration and a per-requester
// lock that keeps multi-byte messages contiguous.
// Optional macro UART_ARB_TIMEOUT_EN: abort a WRITE that sees no uart_ack
// within TIMEOUT_CYCLES clocks. Without it, WRITE waits indefinitely and
// timeout_o is tied low.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no owner; arbitrate once the transmitter is free
// WRITE     | RXTX strobe held until the UART acknowledges the byte
// WAIT_DONE | byte accepted; wait for the frame to leave the transmitter
module uart_tx_arbiter #(
  parameter logic [7:0]  UART_ADDR      = 8'd0,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  input  logic        req0_lock,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  input  logic        req1_lock,
  output logic        req1_ready,
  output logic [15:0] uart_data_write,
  output logic [7:0]  uart_addr,
  output logic        uart_uds,
  output logic        uart_lds,
  output logic        uart_rw,
  input  logic        uart_ack,
  input  logic        uart_tx_active,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        timeout_o
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_last, w_last_nxt;
  logic        r_lock_vld, w_lock_vld_nxt;
  logic        r_lock_id, w_lock_id_nxt;
  logic        r_uds, w_uds_nxt;
  logic        r_rw, w_rw_nxt;
  logic [7:0]  r_addr, w_addr_nxt;
  logic [15:0] r_data, w_data_nxt;
  logic [1:0]  r_grant, w_grant_nxt;
  logic        r_ready0, w_ready0_nxt;
  logic        r_ready1, w_ready1_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_timeout, w_timeout_nxt;

  logic w_elig0, w_elig1, w_arb, w_pick1, w_timeout;

  // A held lock makes only its owner eligible; the other side simply waits.
  assign w_elig0 = req0_valid && (!r_lock_vld || !r_lock_id);
  assign w_elig1 = req1_valid && (!r_lock_vld ||  r_lock_id);
  assign w_arb   = !uart_tx_active && (w_elig0 || w_elig1);
  assign w_pick1 = w_elig1 && (!w_elig0 || !r_last);

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] r_cnt;

  // Cycle counter for the current WRITE; parked at zero outside WRITE so it
  // starts from zero on every entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                r_cnt <= 16'd0;
    else if (r_state != S_WRITE) r_cnt <= 16'd0;
    else                         r_cnt <= r_cnt + 16'd1;
  end

  assign w_timeout = (r_state == S_WRITE) && !uart_ack &&
                     (r_cnt == TIMEOUT_CYCLES - 16'd1);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  // State register and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_lock_vld <= 1'b0;
      r_lock_id  <= 1'b0;
      r_uds      <= 1'b0;
      r_rw       <= 1'b1;
      r_addr     <= 8'd0;
      r_data     <= 16'd0;
      r_grant    <= 2'b00;
      r_ready0   <= 1'b0;
      r_ready1   <= 1'b0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_lock_vld <= w_lock_vld_nxt;
      r_lock_id  <= w_lock_id_nxt;
      r_uds      <= w_uds_nxt;
      r_rw       <= w_rw_nxt;
      r_addr     <= w_addr_nxt;
      r_data     <= w_data_nxt;
      r_grant    <= w_grant_nxt;
      r_ready0   <= w_ready0_nxt;
      r_ready1   <= w_ready1_nxt;
      r_busy     <= w_busy_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_arb) w_state_nxt = S_WRITE;
      S_WRITE: begin
        if (uart_ack)       w_state_nxt = S_WAIT_DONE;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      S_WAIT_DONE: if (!uart_tx_active) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and arbitration bookkeeping.
  always_comb begin
    w_last_nxt     = r_last;
    w_lock_vld_nxt = r_lock_vld;
    w_lock_id_nxt  = r_lock_id;
    w_uds_nxt      = r_uds;
    w_rw_nxt       = r_rw;
    w_addr_nxt     = r_addr;
    w_data_nxt     = r_data;
    w_grant_nxt    = r_grant;
    w_ready0_nxt   = 1'b0;
    w_ready1_nxt   = 1'b0;
    w_timeout_nxt  = 1'b0;
    w_busy_nxt     = (w_state_nxt != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_arb) begin
          w_uds_nxt   = 1'b1;
          w_rw_nxt    = 1'b0;
          w_addr_nxt  = UART_ADDR;
          w_data_nxt  = {8'h00, (w_pick1 ? req1_data : req0_data)};
          w_grant_nxt = w_pick1 ? 2'b10 : 2'b01;
          w_last_nxt  = w_pick1;
        end
      end
      S_WRITE: begin
        if (uart_ack || w_timeout) begin
          w_uds_nxt    = 1'b0;
          w_rw_nxt     = 1'b1;
          w_addr_nxt   = 8'd0;
          w_data_nxt   = 16'd0;
          w_ready0_nxt = r_grant[0];
          w_ready1_nxt = r_grant[1];
        end
        if (uart_ack) begin
          // Lock is sampled alongside the ack, i.e. for the byte just sent.
          w_lock_vld_nxt = r_grant[1] ? req1_lock : req0_lock;
          w_lock_id_nxt  = r_grant[1];
        end else if (w_timeout) begin
          w_timeout_nxt  = 1'b1;
          w_lock_vld_nxt = 1'b0;
          w_grant_nxt    = 2'b00;
        end
      end
      S_WAIT_DONE: if (!uart_tx_active) w_grant_nxt = 2'b00;
      default: ;
    endcase
  end

  assign req0_ready      = r_ready0;
  assign req1_ready      = r_ready1;
  assign uart_data_write = r_data;
  assign uart_addr       = r_addr;
  assign uart_uds        = r_uds;
  assign uart_lds        = 1'b0;
  assign uart_rw         = r_rw;
  assign grant           = r_grant;
  assign busy            = r_busy;
  assign timeout_o       = r_timeout;

endmodule
